// File: rtl/router_pkg.sv
// router_pkg: shared widths, constants and types for the 1x3 packet router.
//   BYTE_W       - datapath byte width
//   ADDR_W       - width of the destination address field in the header
//   ADDR_INVALID - address code with no output port behind it
//   byte_t       - one datapath byte
package router_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage : router_pkg

// File: rtl/router_parity_chk.sv
// router_parity_chk: running XOR parity over header + payload, capture of the
// packet's trailing parity byte, and the registered mismatch flag.
// Ports:
//   clock, resetn     - clock, async active-low reset
//   detect_add        - start of a new packet, clears all parity state
//   lfd_state         - header is being forwarded, folded into parity
//   ld_state          - payload / parity byte is on data_in
//   full_state        - FIFO-full wait state, parity must not advance
//   laf_state         - held byte is being replayed
//   pkt_valid         - data_in carries payload (low: parity byte)
//   fifo_full         - selected FIFO is full
//   low_packet_valid  - parity byte has been seen on data_in
//   parity_done       - parity byte has been captured
//   data_in           - input byte
//   header            - latched header byte
//   hold              - byte parked while the FIFO was full
//   err               - internal parity differs from the packet parity
module router_parity_chk
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              low_packet_valid,
    input  logic              parity_done,
    input  logic [BYTE_W-1:0] data_in,
    input  logic [BYTE_W-1:0] header,
    input  logic [BYTE_W-1:0] hold,
    output logic              err
);

    byte_t int_parity_q;
    byte_t pkt_parity_q;

    // Running parity of every byte actually forwarded for this packet
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity_q <= '0;
        end else if (detect_add) begin
            int_parity_q <= '0;
        end else if (lfd_state) begin
            int_parity_q <= int_parity_q ^ header;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity_q <= int_parity_q ^ data_in;
        end
    end

    // Parity byte arrives either directly or, if the FIFO was full, via hold
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_parity_q <= '0;
        end else if (detect_add) begin
            pkt_parity_q <= '0;
        end else if (ld_state && !fifo_full && !pkt_valid) begin
            pkt_parity_q <= data_in;
        end else if (laf_state && low_packet_valid && !parity_done) begin
            pkt_parity_q <= hold;
        end
    end

    // Compared one cycle after capture so both parities are settled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_parity_q != pkt_parity_q);
        end
    end

endmodule : router_parity_chk

// File: rtl/router_register.sv
// router_register: datapath register block of the 1x3 packet router.
// Latches the header, stages bytes onto the FIFO write bus, parks one byte
// while the FIFO is full and tracks end-of-packet / parity status.
// Parity checking is built only when ROUTER_REG_PARITY_CHECK_EN is defined;
// otherwise err is tied low.
// Ports:
//   clock, resetn        - clock, async active-low reset
//   pkt_valid            - data_in is header/payload (low: parity byte)
//   data_in[7:0]         - input byte, header = {len[5:0], addr[1:0]}
//   fifo_full            - selected output FIFO is full
//   detect_add           - FSM in DECODE_ADDRESS
//   ld_state             - FSM in LOAD_DATA
//   full_state           - FSM in FIFO_FULL_STATE
//   laf_state            - FSM in LOAD_AFTER_FULL
//   lfd_state            - FSM in LOAD_FIRST_DATA
//   rst_int_reg          - clears low_packet_valid
//   err                  - parity mismatch
//   parity_done          - parity byte captured
//   low_packet_valid     - pkt_valid fell during LOAD_DATA
//   dout[7:0]            - byte to the FIFO write bus
module router_register
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    input  logic              lfd_state,
    input  logic              rst_int_reg,
    output logic              err,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic [BYTE_W-1:0] dout
);

    byte_t header_q;
    byte_t hold_q;
    logic  parity_cap_c;

    // Parity byte taken straight from the input or replayed from hold
    assign parity_cap_c = (ld_state && !fifo_full && !pkt_valid)
                        || (laf_state && low_packet_valid && !parity_done);

    // Header with an unroutable address is dropped; previous header kept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_q <= '0;
        end else if (detect_add && pkt_valid
                     && (data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
            header_q <= data_in;
        end
    end

    // Byte that could not be written because the FIFO was full
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
        end else if (ld_state && fifo_full) begin
            hold_q <= data_in;
        end
    end

    // FIFO write bus
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= header_q;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= hold_q;
        end
    end

    // End-of-packet marker; the FSM's clear wins over a same-cycle set
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

    // Parity byte captured
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (parity_cap_c) begin
            parity_done <= 1'b1;
        end
    end

`ifdef ROUTER_REG_PARITY_CHECK_EN
    router_parity_chk u_parity_chk (
        .clock            (clock),
        .resetn           (resetn),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .full_state       (full_state),
        .laf_state        (laf_state),
        .pkt_valid        (pkt_valid),
        .fifo_full        (fifo_full),
        .low_packet_valid (low_packet_valid),
        .parity_done      (parity_done),
        .data_in          (data_in),
        .header           (header_q),
        .hold             (hold_q),
        .err              (err)
    );
`else
    logic parity_unused_c;

    // full_state only steers the parity accumulator
    assign parity_unused_c = full_state;
    assign err             = 1'b0;
`endif

endmodule : router_register

// File: tb/tb_router_register.sv
// tb_router_register: randomized + directed bench for router_register with a
// cycle-level reference model and packet-level parity expectations.
module tb_router_register;

`ifdef ROUTER_REG_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int ST_IDLE = 0;
    localparam int ST_DET  = 1;
    localparam int ST_LFD  = 2;
    localparam int ST_LD   = 3;
    localparam int ST_FULL = 4;
    localparam int ST_LAF  = 5;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic       err;
    logic       parity_done;
    logic       low_packet_valid;
    logic [7:0] dout;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] last_hdr;

    router_register dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .full_state       (full_state),
        .laf_state        (laf_state),
        .lfd_state        (lfd_state),
        .rst_int_reg      (rst_int_reg),
        .err              (err),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .dout             (dout)
    );

    always #5 clock = ~clock;

    // Reference model: register-transfer rules of the block, written directly
    logic [7:0] m_hdr, m_hold, m_dout, m_ipar, m_ppar;
    logic       m_lpv, m_pd, m_err;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_hdr <= 8'h00; m_hold <= 8'h00; m_dout <= 8'h00;
            m_ipar <= 8'h00; m_ppar <= 8'h00;
            m_lpv <= 1'b0; m_pd <= 1'b0; m_err <= 1'b0;
        end else begin
            if (detect_add && pkt_valid && data_in[1:0] != 2'b11) m_hdr <= data_in;
            if (ld_state && fifo_full) m_hold <= data_in;
            if (lfd_state) m_dout <= m_hdr;
            else if (ld_state && !fifo_full) m_dout <= data_in;
            else if (laf_state) m_dout <= m_hold;
            if (detect_add) m_ipar <= 8'h00;
            else if (lfd_state) m_ipar <= m_ipar ^ m_hdr;
            else if (ld_state && pkt_valid && !full_state) m_ipar <= m_ipar ^ data_in;
            if (detect_add) m_ppar <= 8'h00;
            else if (ld_state && !fifo_full && !pkt_valid) m_ppar <= data_in;
            else if (laf_state && m_lpv && !m_pd) m_ppar <= m_hold;
            if (rst_int_reg) m_lpv <= 1'b0;
            else if (ld_state && !pkt_valid) m_lpv <= 1'b1;
            if (detect_add) m_pd <= 1'b0;
            else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && m_lpv && !m_pd)) m_pd <= 1'b1;
            if (detect_add) m_err <= 1'b0;
            else if (m_pd) m_err <= PAR_EN && (m_ipar != m_ppar);
        end
    end

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%02h expected=%02h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            chk8("cyc_dout", dout, m_dout);
            chk1("cyc_err", err, m_err);
            chk1("cyc_parity_done", parity_done, m_pd);
            chk1("cyc_low_packet_valid", low_packet_valid, m_lpv);
        end
    end

    task automatic idle();
        pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
        detect_add = 1'b0; ld_state = 1'b0; full_state = 1'b0;
        laf_state = 1'b0; lfd_state = 1'b0; rst_int_reg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of FSM state + inputs, return 1 time unit after the edge
    task automatic put(input int st, input logic pv, input logic [7:0] d,
                       input logic ff, input logic rir);
        idle();
        detect_add = (st == ST_DET);
        lfd_state  = (st == ST_LFD);
        ld_state   = (st == ST_LD);
        full_state = (st == ST_FULL);
        laf_state  = (st == ST_LAF);
        pkt_valid  = pv;
        data_in    = d;
        fifo_full  = ff;
        rst_int_reg = rir;
        tick();
    endtask

    // One whole packet the way the router FSM would sequence it
    task automatic send_pkt(input logic [7:0] hdr, input int len, input bit bad, input int full_pct);
        logic [7:0] x;
        logic [7:0] b;
        bit last;
        bit ff;
        b = 8'h00;
        put(ST_DET, 1'b1, hdr, 1'b0, 1'b0);
        if (hdr[1:0] != 2'b11) last_hdr = hdr;
        put(ST_LFD, 1'b1, 8'($urandom), 1'b0, 1'b0);
        x = last_hdr;
        for (int i = 0; i <= len; i++) begin
            last = (i == len);
            if (!last) begin
                b = 8'($urandom);
                x = x ^ b;
            end else begin
                b = bad ? (x ^ 8'(1 + ($urandom % 255))) : x;
            end
            ff = int'($urandom_range(99)) < full_pct;
            put(ST_LD, !last, b, ff, 1'b0);
            if (ff) begin
                repeat (1 + ($urandom % 2)) put(ST_FULL, !last, 8'($urandom), 1'b1, 1'b0);
                put(ST_LAF, !last, 8'($urandom), 1'b0, 1'b0);
            end
        end
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("pkt_parity_done", parity_done, 1'b1);
        chk1("pkt_low_packet_valid", low_packet_valid, 1'b1);
        chk1("pkt_err", err, PAR_EN && (b != x));
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk8("rst_async_dout", dout, 8'h00);
        chk1("rst_async_pd", parity_done, 1'b0);
        chk1("rst_async_lpv", low_packet_valid, 1'b0);
        chk1("rst_async_err", err, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        tick();
        chk8("rst_rel_dout", dout, 8'h00);
        chk1("rst_rel_pd", parity_done, 1'b0);

        // Good packet: 0x16, 01..05, parity 0x17
        put(ST_DET, 1'b1, 8'h16, 1'b0, 1'b0);
        put(ST_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
        chk8("good_hdr", dout, 8'h16);
        for (int i = 1; i <= 5; i++) begin
            put(ST_LD, 1'b1, 8'(i), 1'b0, 1'b0);
            chk8("good_payload", dout, 8'(i));
        end
        put(ST_LD, 1'b0, 8'h17, 1'b0, 1'b0);
        chk1("good_pd", parity_done, 1'b1);
        chk1("good_lpv", low_packet_valid, 1'b1);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("good_err", err, 1'b0);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
        chk1("rir_clear", low_packet_valid, 1'b0);

        // Mid-cycle reset with live state
        #3 resetn = 1'b0;
        #1;
        chk8("rst_mid_dout", dout, 8'h00);
        chk1("rst_mid_pd", parity_done, 1'b0);
        @(negedge clock) resetn = 1'b1;
        tick();

        // Bad parity 0x18
        put(ST_DET, 1'b1, 8'h16, 1'b0, 1'b0);
        put(ST_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) put(ST_LD, 1'b1, 8'(i), 1'b0, 1'b0);
        put(ST_LD, 1'b0, 8'h18, 1'b0, 1'b0);
        chk1("bad_pd", parity_done, 1'b1);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("bad_err", err, PAR_EN);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
        chk1("bad_err_hold", err, PAR_EN);
        put(ST_DET, 1'b1, 8'h16, 1'b0, 1'b0);
        chk1("det_clr_err", err, 1'b0);
        chk1("det_clr_pd", parity_done, 1'b0);

        // FIFO full on byte 0x03
        put(ST_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
        chk8("full_hdr", dout, 8'h16);
        put(ST_LD, 1'b1, 8'h01, 1'b0, 1'b0);
        put(ST_LD, 1'b1, 8'h02, 1'b0, 1'b0);
        put(ST_LD, 1'b1, 8'h03, 1'b1, 1'b0);
        chk8("full_hold_dout", dout, 8'h02);
        put(ST_FULL, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk8("full_state_dout", dout, 8'h02);
        put(ST_LAF, 1'b1, 8'hBB, 1'b0, 1'b0);
        chk8("laf_replay", dout, 8'h03);
        put(ST_LD, 1'b1, 8'h04, 1'b0, 1'b0);
        chk8("full_after", dout, 8'h04);
        put(ST_LD, 1'b1, 8'h05, 1'b0, 1'b0);
        put(ST_LD, 1'b0, 8'h17, 1'b0, 1'b0);
        chk1("full_pd", parity_done, 1'b1);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("full_err", err, 1'b0);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);

        // Invalid address keeps previous header; rst_int_reg priority
        put(ST_DET, 1'b1, 8'h17, 1'b0, 1'b0);
        put(ST_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
        chk8("inv_addr_hdr", dout, 8'h16);
        put(ST_LD, 1'b0, 8'h16, 1'b0, 1'b0);
        chk1("lpv_set", low_packet_valid, 1'b1);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
        chk1("lpv_rir", low_packet_valid, 1'b0);
        put(ST_LD, 1'b0, 8'h16, 1'b0, 1'b1);
        chk1("lpv_rir_wins", low_packet_valid, 1'b0);
        put(ST_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized packets
        last_hdr = 8'h16;
        for (int p = 0; p < 150; p++) begin
            int len;
            logic [1:0] a;
            len = 1 + int'($urandom % 12);
            a = 2'($urandom);
            send_pkt({6'(len), a}, len, ($urandom % 3) == 0, 25);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_router_register
